// File: rtl/chroni_vram_arbiter_if.sv
// Bus bundle between the chroni VRAM arbiter, its display/CPU clients and the RAM.
interface chroni_vram_arbiter_if;
  localparam int unsigned ADDR_W = 11;
  localparam int unsigned DATA_W = 8;

  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic [DATA_W-1:0] disp_data;
  logic              disp_valid;
  logic              disp_miss;
  logic [7:0]        disp_miss_cnt;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  disp_req, disp_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    output disp_data, disp_valid, disp_miss, disp_miss_cnt, cpu_ack, cpu_rdata,
           mem_addr, mem_we, mem_wdata
  );

  modport master (
    output disp_req, disp_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    input  disp_data, disp_valid, disp_miss, disp_miss_cnt, cpu_ack, cpu_rdata,
           mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/chroni_vram_arbiter.sv
// Single-port VRAM arbiter: display fetch has priority, CPU gets a slot after
// at most MAX_WAIT lost slots; forced CPU slots are reported as display misses.
module chroni_vram_arbiter #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic                  vga_clk,
  input  logic                  reset_n,
  chroni_vram_arbiter_if.slave  bus
);
  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] MAX_WAIT_C = CNT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUED,
    ST_ACK
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] wait_nxt;
  logic             cpu_slot_c;

  // State and wait counter
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  // Slot decision and next state; wait_cnt only survives while a request keeps losing
  always_comb begin
    state_nxt  = state;
    wait_nxt   = '0;
    cpu_slot_c = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.cpu_req) begin
          if (!bus.disp_req || (wait_cnt >= MAX_WAIT_C)) begin
            cpu_slot_c = 1'b1;
            state_nxt  = ST_ISSUED;
          end else begin
            wait_nxt = wait_cnt + CNT_W'(1);
          end
        end
      end
      ST_ISSUED: state_nxt = ST_ACK;
      ST_ACK:    state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // RAM port follows the slot owner; held quiet during reset
  assign bus.mem_we    = reset_n & cpu_slot_c & bus.cpu_we;
  assign bus.mem_addr  = !reset_n ? '0 : (cpu_slot_c ? bus.cpu_addr : bus.disp_addr);
  assign bus.mem_wdata = bus.cpu_wdata;
  assign bus.disp_data = bus.mem_rdata;

  // Registered client-side status
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.disp_valid    <= 1'b0;
      bus.disp_miss     <= 1'b0;
      bus.disp_miss_cnt <= '0;
      bus.cpu_ack       <= 1'b0;
      bus.cpu_rdata     <= '0;
    end else begin
      bus.disp_valid <= bus.disp_req & ~cpu_slot_c;
      bus.disp_miss  <= bus.disp_req & cpu_slot_c;
      if (bus.disp_req && cpu_slot_c && (bus.disp_miss_cnt != CNT_MAX)) begin
        bus.disp_miss_cnt <= bus.disp_miss_cnt + CNT_W'(1);
      end
      bus.cpu_ack <= (state == ST_ISSUED);
      if ((state == ST_ISSUED) && !bus.cpu_we) begin
        bus.cpu_rdata <= bus.mem_rdata;
      end
    end
  end
endmodule

// File: tb/tb_chroni_vram_arbiter.sv
// Randomized and directed bench for chroni_vram_arbiter against a cycle-schedule model.
module tb_chroni_vram_arbiter;
  localparam int unsigned MW = 3;

  logic vga_clk = 1'b0;
  logic reset_n;
  always #5 vga_clk = ~vga_clk;

  chroni_vram_arbiter_if bus ();

  chroni_vram_arbiter #(.MAX_WAIT(MW)) u_dut (
    .vga_clk (vga_clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Synchronous 2K x 8 RAM, read-before-write
  logic [7:0] ram [2048];
  always @(posedge vga_clk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  int          checks;
  int          errors;
  int          cyc;
  int          ack_cycle;
  int unsigned wait_n;
  logic [7:0]  m_ram [2048];
  logic [7:0]  e_cnt;
  logic [7:0]  e_rdata;
  logic [7:0]  p_data;
  bit          p_read;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: inputs already driven; check RAM port, then registered outputs
  task automatic tick();
    bit         busy;
    bit         win;
    bit         nx_valid;
    bit         nx_miss;
    bit         ack_now;
    logic [7:0] nx_data;
    #2;
    busy = (ack_cycle >= cyc);
    win  = !busy && bus.cpu_req && (!bus.disp_req || (wait_n >= MW));
    if (!busy && bus.cpu_req && !win) wait_n++;
    else wait_n = 0;
    check("mem_we", 32'(bus.mem_we), 32'(win && bus.cpu_we));
    check("mem_addr", 32'(bus.mem_addr), 32'(win ? bus.cpu_addr : bus.disp_addr));
    check("mem_wdata", 32'(bus.mem_wdata), 32'(bus.cpu_wdata));
    nx_valid = bus.disp_req && !win;
    nx_miss  = bus.disp_req && win;
    nx_data  = m_ram[bus.disp_addr];
    if (win) begin
      ack_cycle = cyc + 2;
      p_read    = !bus.cpu_we;
      p_data    = m_ram[bus.cpu_addr];
      if (bus.cpu_we) m_ram[bus.cpu_addr] = bus.cpu_wdata;
    end
    if (nx_miss && (e_cnt != 8'hFF)) e_cnt++;
    @(posedge vga_clk);
    #1;
    cyc++;
    check("disp_valid", 32'(bus.disp_valid), 32'(nx_valid));
    check("disp_miss", 32'(bus.disp_miss), 32'(nx_miss));
    check("disp_miss_cnt", 32'(bus.disp_miss_cnt), 32'(e_cnt));
    if (nx_valid) check("disp_data", 32'(bus.disp_data), 32'(nx_data));
    ack_now = (ack_cycle == cyc);
    if (ack_now && p_read) e_rdata = p_data;
    check("cpu_ack", 32'(bus.cpu_ack), 32'(ack_now));
    check("cpu_rdata", 32'(bus.cpu_rdata), 32'(e_rdata));
  endtask

  // dmode: 0 display idle, 1 display always requesting, 2 display only while CPU is busy
  task automatic cpu_access(input bit we, input logic [10:0] addr, input logic [7:0] wd,
                            input int dmode, input bit keep, input int exp_lat);
    int n;
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wd;
    n = 0;
    do begin
      bus.disp_req  = (dmode == 1) || ((dmode == 2) && (ack_cycle >= cyc));
      bus.disp_addr = 11'($urandom);
      tick();
      n++;
    end while (!bus.cpu_ack && (n < 64));
    if (!bus.cpu_ack) check("cpu_ack_timeout", 32'(bus.cpu_ack), 32'(1));
    if (exp_lat >= 0) check("cpu_latency", 32'(n), 32'(exp_lat));
    if (!keep) bus.cpu_req = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_disp_valid"}, 32'(bus.disp_valid), 32'(0));
    check({tag, "_disp_miss"}, 32'(bus.disp_miss), 32'(0));
    check({tag, "_miss_cnt"}, 32'(bus.disp_miss_cnt), 32'(0));
    check({tag, "_cpu_ack"}, 32'(bus.cpu_ack), 32'(0));
    check({tag, "_cpu_rdata"}, 32'(bus.cpu_rdata), 32'(0));
    check({tag, "_mem_we"}, 32'(bus.mem_we), 32'(0));
    check({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'(0));
  endtask

  task automatic model_reset();
    ack_cycle = -10;
    wait_n    = 0;
    e_cnt     = 8'h00;
    e_rdata   = 8'h00;
    p_read    = 1'b0;
  endtask

  initial begin
    int         acks;
    logic [10:0] a;
    logic [7:0]  d;
    checks = 0;
    errors = 0;
    cyc    = 0;
    p_data = 8'h00;
    model_reset();
    for (int i = 0; i < 2048; i++) begin
      ram[i]   = 8'($urandom);
      m_ram[i] = ram[i];
    end

    // Reset: outputs zero even with inputs active
    reset_n       = 1'b0;
    bus.disp_req  = 1'b1;
    bus.disp_addr = 11'h7FF;
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = 11'h7FF;
    bus.cpu_wdata = 8'hFF;
    repeat (3) @(posedge vga_clk);
    #1;
    check_all_zero("reset");
    bus.disp_req = 1'b0;
    bus.cpu_req  = 1'b0;
    bus.cpu_we   = 1'b0;
    reset_n      = 1'b1;
    tick();

    // Write 0x5A to 0x123 then read it back, display idle
    cpu_access(1'b1, 11'h123, 8'h5A, 0, 1'b0, 2);
    tick();
    cpu_access(1'b0, 11'h123, 8'h00, 0, 1'b0, 2);
    check("read_back_5a", 32'(bus.cpu_rdata), 32'(8'h5A));
    tick();

    // Display stream 0x400..0x40F, CPU idle
    for (int i = 0; i < 16; i++) begin
      bus.disp_req  = 1'b1;
      bus.disp_addr = 11'(11'h400 + i);
      tick();
    end
    bus.disp_req = 1'b0;
    tick();

    // Display saturating: CPU read forced after MW lost slots
    cpu_access(1'b0, 11'h010, 8'h00, 1, 1'b0, int'(MW) + 2);
    check("miss_cnt_first_force", 32'(bus.disp_miss_cnt), 32'(1));
    bus.disp_req = 1'b0;
    tick();

    // Back-to-back, request held through ACK; display served in ISSUED/ACK slots
    a = 11'($urandom);
    d = 8'($urandom);
    cpu_access(1'b1, a, d, 2, 1'b1, 2);
    cpu_access(1'b0, a, 8'h00, 2, 1'b0, 3);
    check("b2b_read_back", 32'(bus.cpu_rdata), 32'(d));
    bus.disp_req = 1'b0;
    tick();

    // Reset while ISSUED; held request re-granted and acked exactly once
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = 11'h123;
    bus.cpu_wdata = 8'h00;
    bus.disp_req  = 1'b0;
    tick();
    #1;
    reset_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    model_reset();
    @(posedge vga_clk);
    #1;
    reset_n = 1'b1;
    cpu_access(1'b0, 11'h123, 8'h00, 0, 1'b0, 2);
    acks = 0;
    repeat (6) begin
      tick();
      acks += int'(bus.cpu_ack);
    end
    check("post_reset_extra_ack", 32'(acks), 32'(0));

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      bus.disp_req  = ($urandom_range(0, 3) != 0);
      bus.disp_addr = 11'($urandom);
      if (!bus.cpu_req && ($urandom_range(0, 2) == 0)) begin
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'($urandom);
        bus.cpu_addr  = 11'($urandom_range(0, 63));
        bus.cpu_wdata = 8'($urandom);
      end
      tick();
      if (ack_cycle == cyc) begin
        if ($urandom_range(0, 1) == 1) begin
          bus.cpu_we    = 1'($urandom);
          bus.cpu_addr  = 11'($urandom_range(0, 63));
          bus.cpu_wdata = 8'($urandom);
        end else begin
          bus.cpu_req = 1'b0;
        end
      end
    end
    bus.cpu_req  = 1'b0;
    bus.disp_req = 1'b0;
    repeat (4) tick();

    // 300 forced collisions: miss counter saturates
    for (int k = 0; k < 300; k++) begin
      cpu_access(1'($urandom), 11'($urandom), 8'($urandom), 1, 1'b1, -1);
    end
    bus.cpu_req  = 1'b0;
    bus.disp_req = 1'b0;
    tick();
    tick();
    check("miss_cnt_saturated", 32'(bus.disp_miss_cnt), 32'(255));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
